// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer that oversamples the line with baud_tick,
// finds the start bit, samples each bit at mid-period, assembles the data word
// and reports one completed frame per done_flag with parity/framing status.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   baud_tick    single-cycle strobe, OVERSAMPLE pulses per bit period
//   rx_in        raw serial line (idle high, asynchronous to clk)
//   rx_enable    allows a new start bit to be accepted
//   parity_type  00/11 none, 01 odd, 10 even (latched at start of frame)
//   stop_bits    0 one stop bit, 1 two stop bits (latched at start of frame)
//   shift_en     one-cycle pulse per sampled data bit
//   sampled_bit  line value of the bit just sampled, valid with shift_en
//   data_out     last received word, first received bit in the LSB
//   done_flag    one-cycle pulse at frame end
//   parity_error parity mismatch in the last frame
//   frame_error  a stop bit of the last frame was sampled low
//   busy         high whenever the sequencer is not idle
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic                 rx_enable,
    input  logic [1:0]           parity_type,
    input  logic                 stop_bits,
    output logic                 shift_en,
    output logic                 sampled_bit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done_flag,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           cfg_par_q, cfg_par_d;
    logic                 cfg_stop_q, cfg_stop_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 par_acc_q, par_acc_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 shift_en_q, shift_en_d;
    logic                 sampled_bit_q, sampled_bit_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 done_flag_q, done_flag_d;
    logic                 parity_error_q, parity_error_d;
    logic                 frame_error_q, frame_error_d;
    logic                 busy_q, busy_d;
    logic                 rx, tick_hit, par_on;

    assign rx       = sync2_q;
    assign par_on   = ^cfg_par_q;
    // START waits half a bit to land mid-bit; every later sample is one full bit on
    assign tick_hit = baud_tick && (tick_cnt_q == ((state_q == START) ? HALF_LAST : FULL_LAST));

    always_comb begin
        sync1_d        = rx_in;
        sync2_d        = sync1_q;
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        cfg_par_d      = cfg_par_q;
        cfg_stop_d     = cfg_stop_q;
        word_d         = word_q;
        par_acc_d      = par_acc_q;
        perr_d         = perr_q;
        ferr_d         = ferr_q;
        shift_en_d     = 1'b0;
        sampled_bit_d  = sampled_bit_q;
        data_out_d     = data_out_q;
        done_flag_d    = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
        if (state_q != IDLE && state_q != DONE && baud_tick)
            tick_cnt_d = tick_hit ? '0 : tick_cnt_q + TW'(1);
        case (state_q)
            IDLE: begin
                if (baud_tick && rx_enable && !rx) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    cfg_par_d  = parity_type;
                    cfg_stop_d = stop_bits;
                    word_d     = '0;
                    par_acc_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            START: begin
                if (tick_hit)
                    state_d = rx ? IDLE : DATA;
            end
            DATA: begin
                if (tick_hit) begin
                    shift_en_d    = 1'b1;
                    sampled_bit_d = rx;
                    word_d        = {rx, word_q[DATA_BITS-1:1]};
                    par_acc_d     = par_acc_q ^ rx;
                    bit_cnt_d     = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BITS_LAST) begin
                        state_d   = par_on ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end
                end
            end
            PARITY: begin
                // odd parity errs when the total ones count is even, even parity when odd
                if (tick_hit) begin
                    perr_d  = par_acc_q ^ rx ^ (cfg_par_q == 2'b01);
                    state_d = STOP;
                end
            end
            STOP: begin
                // bit_cnt now counts stop samples; the full stop period is always consumed
                if (tick_hit) begin
                    ferr_d    = ferr_q | ~rx;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(cfg_stop_q)) begin
                        state_d        = DONE;
                        done_flag_d    = 1'b1;
                        data_out_d     = word_q;
                        parity_error_d = perr_q;
                        frame_error_d  = ferr_q | ~rx;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            cfg_par_q      <= 2'b00;
            cfg_stop_q     <= 1'b0;
            word_q         <= '0;
            par_acc_q      <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            shift_en_q     <= 1'b0;
            sampled_bit_q  <= 1'b0;
            data_out_q     <= '0;
            done_flag_q    <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            tick_cnt_q     <= tick_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            cfg_par_q      <= cfg_par_d;
            cfg_stop_q     <= cfg_stop_d;
            word_q         <= word_d;
            par_acc_q      <= par_acc_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            shift_en_q     <= shift_en_d;
            sampled_bit_q  <= sampled_bit_d;
            data_out_q     <= data_out_d;
            done_flag_q    <= done_flag_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
            busy_q         <= busy_d;
        end
    end

    assign shift_en     = shift_en_q;
    assign sampled_bit  = sampled_bit_q;
    assign data_out     = data_out_q;
    assign done_flag    = done_flag_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scoreboard bench for uart_rx_ctrl (OVERSAMPLE=16, DATA_BITS=8,
// one baud_tick every 4 clocks, so one bit period is 64 clocks).
module tb_uart_rx_ctrl;
    localparam int BP = 64;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, baud_tick = 1'b0, rx_in = 1'b1;
    logic       rx_enable = 1'b0, stop_bits = 1'b0;
    logic [1:0] parity_type = 2'b00;
    logic       shift_en, sampled_bit, done_flag, parity_error, frame_error, busy;
    logic [7:0] data_out;

    exp_t exp_q[$];
    logic bit_q[$];
    int   total = 0, bad = 0, done_cnt = 0, shift_cnt = 0, cyc = 0, last_shift = 0, done_gap = 0;
    int   tdiv = 0;
    logic prev_done = 1'b0;

    uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx_in),
        .rx_enable(rx_enable), .parity_type(parity_type), .stop_bits(stop_bits),
        .shift_en(shift_en), .sampled_bit(sampled_bit), .data_out(data_out),
        .done_flag(done_flag), .parity_error(parity_error), .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            tdiv      = (tdiv == 3) ? 0 : tdiv + 1;
            baud_tick = (tdiv == 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic b;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                shift_cnt = 0;
                prev_done = 1'b0;
            end else begin
                if (shift_en) begin
                    chk("bit_avail", bit_q.size() > 0, 1);
                    if (bit_q.size() > 0) begin
                        b = bit_q.pop_front();
                        chk("sampled_bit", sampled_bit, b);
                    end
                    shift_cnt++;
                    last_shift = cyc;
                end
                if (done_flag) begin
                    chk("done_width", prev_done, 0);
                    chk("exp_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("data_out", data_out, e.d);
                        chk("parity_error", parity_error, e.pe);
                        chk("frame_error", frame_error, e.fe);
                    end
                    chk("shift_count", shift_cnt, 8);
                    shift_cnt = 0;
                    done_gap  = cyc - last_shift;
                    done_cnt++;
                end
                prev_done = done_flag;
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                              input logic pbit, input logic s1, input logic s2, input logic mess);
        exp_t e;
        int   ones;
        logic pon;
        pon  = (pt == 2'b01) || (pt == 2'b10);
        ones = $countones(d) + (pon ? int'(pbit) : 0);
        e.d  = d;
        e.pe = (pt == 2'b01) ? (ones % 2 == 0) : (pt == 2'b10) ? (ones % 2 == 1) : 1'b0;
        e.fe = !s1 || (sb && !s2);
        parity_type = pt;
        stop_bits   = sb;
        exp_q.push_back(e);
        rx_in = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (mess && i == 2) begin
                rx_enable   = 1'b0;
                parity_type = 2'b01;
                stop_bits   = 1'b0;
            end
            bit_q.push_back(d[i]);
            rx_in = d[i];
            repeat (BP) @(negedge clk);
        end
        if (pon) begin
            rx_in = pbit;
            repeat (BP) @(negedge clk);
        end
        rx_in = s1;
        repeat (BP) @(negedge clk);
        if (sb) begin
            rx_in = s2;
            repeat (BP) @(negedge clk);
        end
    endtask

    initial begin
        logic       seen;
        logic [7:0] ab;
        repeat (3) @(negedge clk);
        chk("reset_outs", {shift_en, sampled_bit, data_out, done_flag, parity_error, frame_error, busy}, 0);
        rst_n = 1'b1;
        rx_enable = 1'b1;
        repeat (BP) @(negedge clk);
        chk("idle_busy", busy, 0);

        send_frame(8'h55, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("done_cnt_55", done_cnt, 1);

        send_frame(8'hA3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("done_cnt_a3", done_cnt, 2);
        chk("held_perr_a3", parity_error, 1);

        send_frame(8'h0F, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        rx_in = 1'b1;
        repeat (BP) @(negedge clk);
        chk("done_cnt_0f", done_cnt, 3);
        chk("stop_gap", done_gap, 2 * BP);
        chk("held_ferr_0f", frame_error, 1);
        rx_enable   = 1'b1;
        parity_type = 2'b00;
        stop_bits   = 1'b0;

        seen  = 1'b0;
        rx_in = 1'b0;
        repeat (16) begin
            @(negedge clk);
            seen |= busy;
        end
        rx_in = 1'b1;
        chk("glitch_busy", seen, 1);
        repeat (BP) @(negedge clk);
        chk("glitch_idle", busy, 0);
        chk("glitch_done", done_cnt, 3);
        chk("glitch_shift", shift_cnt, 0);

        send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_first", data_out, 8'h12);
        send_frame(8'h34, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_cnt", done_cnt, 5);
        chk("b2b_second", data_out, 8'h34);

        ab    = 8'hC5;
        rx_in = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bit_q.push_back(ab[i]);
            rx_in = ab[i];
            repeat (BP) @(negedge clk);
        end
        rx_in = ab[3];
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_reset_outs", {shift_en, sampled_bit, data_out, done_flag, parity_error, frame_error, busy}, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (BP) @(negedge clk);
        chk("abort_no_done", done_cnt, 5);
        chk("abort_bits_used", bit_q.size(), 0);

        send_frame(8'h7E, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_reset_cnt", done_cnt, 6);
        chk("post_reset_data", data_out, 8'h7E);

        chk("exp_drained", exp_q.size(), 0);
        chk("bits_drained", bit_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
